// File: rtl/demux_stage.sv
// Key-routed demux: one input stream split into two independently back-pressured 2-entry FIFOs.
// Optional transfer counters cnt0/cnt1 are built when DEMUX_STAGE_COUNT_EN is defined.
module demux_stage_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full_next
);
  logic [1:0]   cnt, cnt_nxt;
  logic [W-1:0] mem1;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 2'd1;
    else if (pop && !push) cnt_nxt = cnt - 2'd1;
  end

  assign full_next = (cnt_nxt == 2'd2);
  assign valid     = (cnt != 2'd0);

  // Head always lives in dout so the output is a plain register; mem1 is the second slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      dout <= '0;
      mem1 <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (pop) begin
        dout <= (push && cnt == 2'd1) ? din : mem1;
        if (push && cnt == 2'd2) mem1 <= din;
      end else if (push) begin
        if (cnt == 2'd0) dout <= din;
        else             mem1 <= din;
      end
    end
  end
endmodule

module demux_stage #(
  parameter int BW_IN     = 32,
  parameter int BW_OUT0   = 32,
  parameter int BW_OUT1   = 32,
  parameter int SIGNED_IN = 0,
  parameter int SHIFT1    = 0,
  parameter int INVERT1   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               key,
  input  logic [BW_IN-1:0]   in_data,
  output logic               out0_valid,
  input  logic               out0_ready,
  output logic [BW_OUT0-1:0] out0_data,
  output logic               out1_valid,
  input  logic               out1_ready,
  output logic [BW_OUT1-1:0] out1_data
`ifdef DEMUX_STAGE_COUNT_EN
  ,
  output logic [15:0]        cnt0,
  output logic [15:0]        cnt1
`endif
);
  localparam int W0 = (BW_IN > BW_OUT0) ? BW_IN : BW_OUT0;
  localparam int SA = (SHIFT1 < 0) ? -SHIFT1 : SHIFT1;
  localparam int W1 = ((BW_IN > BW_OUT1) ? BW_IN : BW_OUT1) + SA + 1;

  logic                sgn;
  logic [W0-1:0]       ext0;
  logic [W1-1:0]       ext1;
  logic signed [W1-1:0] sext1;
  logic [BW_OUT0-1:0]  d0;
  logic [BW_OUT1-1:0]  d1;
  logic                push0, push1, pop0, pop1, full0_nxt, full1_nxt;

  // out1 is widened enough that negate and left shift never overflow before truncation.
  always_comb begin
    sgn   = (SIGNED_IN != 0) && in_data[BW_IN-1];
    ext0  = {W0{sgn}};
    ext0[BW_IN-1:0] = in_data;
    ext1  = {W1{sgn}};
    ext1[BW_IN-1:0] = in_data;
    if (INVERT1 != 0) ext1 = -ext1;
    sext1 = ext1;
    if (SHIFT1 > 0) begin
      if (SIGNED_IN != 0 || INVERT1 != 0) ext1 = sext1 >>> SA;
      else                                ext1 = ext1 >> SA;
    end else if (SHIFT1 < 0) begin
      ext1 = ext1 << SA;
    end
    d0 = BW_OUT0'(ext0);
    d1 = BW_OUT1'(ext1);
  end

  assign push0 = in_valid && in_ready && key;
  assign push1 = in_valid && in_ready && !key;
  assign pop0  = out0_valid && out0_ready;
  assign pop1  = out1_valid && out1_ready;

  demux_stage_fifo #(.W(BW_OUT0)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .din(d0), .pop(pop0),
    .valid(out0_valid), .dout(out0_data), .full_next(full0_nxt)
  );

  demux_stage_fifo #(.W(BW_OUT1)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .din(d1), .pop(pop1),
    .valid(out1_valid), .dout(out1_data), .full_next(full1_nxt)
  );

  // Registered so in_ready never depends combinationally on this cycle's handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= !full0_nxt && !full1_nxt;
  end

`ifdef DEMUX_STAGE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= 16'd0;
      cnt1 <= 16'd0;
    end else begin
      if (pop0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (pop1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux_stage.sv
// Scoreboard bench for demux_stage: queue-based model of the two output streams plus
// two 8-bit instances exercising the out1 shift/invert arithmetic.
module tb_demux_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, key;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] out0_data, out1_data;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        a_in_ready, a_out0_valid, a_out1_valid;
  logic [7:0]  a_out0_data, a_out1_data;
  logic        b_in_ready, b_out0_valid, b_out1_valid;
  logic [7:0]  b_out0_data, b_out1_data;
`ifdef DEMUX_STAGE_COUNT_EN
  logic [15:0] cnt0, cnt1, a_cnt0, a_cnt1, b_cnt0, b_cnt1;
`endif

  int ntests = 0;
  int nfail  = 0;
  bit armed  = 0;
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];

  always #5 clk = ~clk;

  demux_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .key(key),
    .in_data(in_data), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef DEMUX_STAGE_COUNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  demux_stage #(.BW_IN(8), .BW_OUT0(8), .BW_OUT1(8), .SIGNED_IN(1), .SHIFT1(2), .INVERT1(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(a_in_ready), .key(1'b0),
    .in_data(s_data), .out0_valid(a_out0_valid), .out0_ready(1'b1), .out0_data(a_out0_data),
    .out1_valid(a_out1_valid), .out1_ready(1'b1), .out1_data(a_out1_data)
`ifdef DEMUX_STAGE_COUNT_EN
    , .cnt0(a_cnt0), .cnt1(a_cnt1)
`endif
  );

  demux_stage #(.BW_IN(8), .BW_OUT0(8), .BW_OUT1(8), .SIGNED_IN(1), .SHIFT1(2), .INVERT1(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(b_in_ready), .key(1'b0),
    .in_data(s_data), .out0_valid(b_out0_valid), .out0_ready(1'b1), .out0_data(b_out0_data),
    .out1_valid(b_out1_valid), .out1_ready(1'b1), .out1_data(b_out1_data)
`ifdef DEMUX_STAGE_COUNT_EN
    , .cnt0(b_cnt0), .cnt1(b_cnt1)
`endif
  );

  // Reference: treat the input as an integer, negate, floor-divide or multiply by 2^|sh|, wrap.
  function automatic logic [63:0] model(input longint raw, input int bwin, input bit sgn,
                                        input int sh, input bit inv, input int bwout);
    longint v;
    v = raw & ((longint'(1) << bwin) - 1);
    if (sgn && v[bwin-1]) v = v - (longint'(1) << bwin);
    if (inv) v = -v;
    if (sh > 0)      v = v >>> sh;
    else if (sh < 0) v = v <<< (-sh);
    return v & ((longint'(1) << bwout) - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (rst_n) armed = 1;

  // Monitor: compare presented outputs with the model queues, then retire/admit words.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, armed && exp0.size() < 2 && exp1.size() < 2);
      chk("out0_valid", out0_valid, exp0.size() != 0);
      chk("out1_valid", out1_valid, exp1.size() != 0);
      if (out0_valid && exp0.size() != 0) chk("out0_data", out0_data, exp0[0]);
      if (out1_valid && exp1.size() != 0) chk("out1_data", out1_data, exp1[0]);
      if (out0_valid && out0_ready && exp0.size() != 0) void'(exp0.pop_front());
      if (out1_valid && out1_ready && exp1.size() != 0) void'(exp1.pop_front());
      if (in_valid && in_ready) begin
        if (key) exp0.push_back(model(longint'(in_data), 32, 0, 0, 0, 32));
        else     exp1.push_back(model(longint'(in_data), 32, 0, 0, 0, 32));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit k, input logic [31:0] d);
    bit ok;
    ok = 0;
    in_valid = 1; key = k; in_data = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    chk("send_accept", ok, 1);
  endtask

  task automatic side(input logic [7:0] d, input logic [7:0] ea, input logic [7:0] eb);
    s_data = d;
    @(posedge clk);
    #1;
    chk("a_out1_valid", a_out1_valid, 1);
    chk("a_out1_data", a_out1_data, ea);
    chk("b_out1_data", b_out1_data, eb);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; key = 0; in_data = 0; out0_ready = 0; out1_ready = 0;
    s_valid = 1; s_data = 0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Basic routing
    out0_ready = 1; out1_ready = 1;
    send(1, 32'h0000_00A5);
    send(0, 32'h0000_005A);
    idle(3);

    // out1 arithmetic on the 8-bit instances
    side(8'h10, 8'hFC, 8'h04);
    side(8'h80, 8'h20, 8'hE0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      side(r, 8'(model(longint'(r), 8, 1, 2, 1, 8)), 8'(model(longint'(r), 8, 1, 2, 0, 8)));
    end

    // Backpressure on out1 stalls input once its FIFO fills
    out1_ready = 0;
    send(0, 32'd1);
    send(0, 32'd2);
    chk("bp_in_ready_full", in_ready, 0);
    in_valid = 1; key = 0; in_data = 32'd3;
    idle(3);
    chk("bp_stall_k0", in_ready, 0);
    key = 1; in_data = 32'h44;
    idle(3);
    chk("bp_stall_k1", in_ready, 0);
    in_valid = 0;
    out1_ready = 1;
    send(0, 32'd3);
    idle(5);

    // Independent outputs: out0 held while out1 streams
    out0_ready = 0;
    send(1, 32'h11);
    send(0, 32'd7);
    send(0, 32'd8);
    send(0, 32'd9);
    idle(4);
    chk("ind_out0_valid", out0_valid, 1);
    chk("ind_out0_hold", out0_data, 32'h11);
    out0_ready = 1;
    idle(3);

    // Reset mid-stream
    out0_ready = 0; out1_ready = 0;
    send(1, 32'h21);
    send(0, 32'h31);
    send(0, 32'h32);
    idle(1);
    #1 rst_n = 0;
    #1;
    chk("mrst_out0_valid", out0_valid, 0);
    chk("mrst_out1_valid", out1_valid, 0);
    chk("mrst_out0_data", out0_data, 0);
    chk("mrst_out1_data", out1_data, 0);
    chk("mrst_in_ready", in_ready, 0);
    armed = 0;
    exp0.delete();
    exp1.delete();
    #1 rst_n = 1;
    out0_ready = 1; out1_ready = 1;
    idle(4);
    chk("post_rst_out0_valid", out0_valid, 0);
    chk("post_rst_out1_valid", out1_valid, 0);

    // Randomized traffic in phases with different backpressure mixes
    for (int p = 0; p < 6; p++) begin
      int rp;
      rp = 1 + p % 3;
      for (int c = 0; c < 500; c++) begin
        in_valid   = ($urandom % 4) != 0;
        key        = 1'($urandom);
        in_data    = $urandom;
        out0_ready = ($urandom % 4) < 4 - rp;
        out1_ready = ($urandom % 4) < rp;
        idle(1);
      end
    end
    in_valid = 0; out0_ready = 1; out1_ready = 1;
    idle(5);
    chk("drain_q0", exp0.size(), 0);
    chk("drain_q1", exp1.size(), 0);

`ifdef DEMUX_STAGE_COUNT_EN
    #1 rst_n = 0;
    armed = 0;
    exp0.delete();
    exp1.delete();
    #1;
    chk("cnt0_rst", cnt0, 0);
    #1 rst_n = 1;
    idle(1);
    in_valid = 1; key = 1; out0_ready = 1; out1_ready = 1;
    for (int c = 0; c < 70000; c++) in_data = $urandom;
    idle(70000);
    in_valid = 0;
    idle(3);
    chk("cnt0_sat", cnt0, 16'hFFFF);
    chk("cnt1_zero", cnt1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
